// File: rtl/bfloat_pkg.sv
// rtl/bfloat_pkg.sv - shared constants, FSM states and field helpers for the bfloat16 accumulator
// Purpose: bfloat16 constants, the accumulator state enum and sign/exp/man extractors.
// Ports: none (package).
package bfloat_pkg;

  localparam logic [15:0] BF16_ZERO    = 16'h0000;
  localparam logic [15:0] BF16_NAN     = 16'hFFFF;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  function automatic logic bf_sign(input logic [15:0] v);
    return v[15];
  endfunction

  function automatic logic [7:0] bf_exp(input logic [15:0] v);
    return v[14:7];
  endfunction

  function automatic logic [6:0] bf_man(input logic [15:0] v);
    return v[6:0];
  endfunction

endpackage

// File: rtl/bfloat_add_reg.sv
// rtl/bfloat_add_reg.sv - registered-input truncating bfloat16 adder, 1-cycle latency
// Purpose: captures operands a/b every clock, then forms their bfloat16 sum
//          combinationally from the captured values (truncating, no rounding).
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset, clears the operand registers
//   a    in   bfloat16 operand
//   b    in   bfloat16 operand
//   sum  out  bfloat16 sum of the operands captured on the previous edge
module bfloat_add_reg
  import bfloat_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [15:0] r_a;
  logic [15:0] r_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= BF16_ZERO;
      r_b <= BF16_ZERO;
    end else begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Order operands by magnitude so the subtract path never goes negative.
  logic        w_a_ge_b;
  logic [15:0] w_big;
  logic [15:0] w_small;
  logic [7:0]  w_e_big;
  logic [7:0]  w_diff;
  logic [7:0]  w_m_big;
  logic [7:0]  w_m_small;
  logic [8:0]  w_sum9;
  logic [7:0]  w_dif8;
  logic        w_same;

  assign w_a_ge_b  = (r_a[14:0] >= r_b[14:0]);
  assign w_big     = w_a_ge_b ? r_a : r_b;
  assign w_small   = w_a_ge_b ? r_b : r_a;
  assign w_e_big   = bf_exp(w_big);
  assign w_diff    = w_e_big - bf_exp(w_small);
  assign w_m_big   = {1'b1, bf_man(w_big)};
  // Alignment simply drops the bits shifted out.
  assign w_m_small = (w_diff > 8'd7) ? 8'd0 : ({1'b1, bf_man(w_small)} >> w_diff[2:0]);
  assign w_sum9    = {1'b0, w_m_big} + {1'b0, w_m_small};
  assign w_dif8    = w_m_big - w_m_small;
  assign w_same    = (bf_sign(w_big) == bf_sign(w_small));

  logic [2:0] w_lz;
  logic [6:0] w_man;

  always_comb begin
    sum   = BF16_ZERO;
    w_lz  = 3'd0;
    w_man = 7'd0;
    // Highest set bit wins because the scan runs upward.
    for (int i = 0; i < 8; i++) begin
      if (w_dif8[i]) w_lz = 3'(7 - i);
    end
    if (bf_exp(r_a) == BF16_EXP_MAX || bf_exp(r_b) == BF16_EXP_MAX) begin
      sum = BF16_NAN;
    end else if (bf_exp(r_a) == 8'd0) begin
      // Exponent 0 is treated as zero; subnormals are flushed.
      sum = r_b;
    end else if (bf_exp(r_b) == 8'd0) begin
      sum = r_a;
    end else if (w_same) begin
      if (w_sum9[8]) begin
        if (w_e_big == 8'hFE) sum = BF16_NAN;
        else sum = {bf_sign(w_big), w_e_big + 8'd1, w_sum9[7:1]};
      end else begin
        sum = {bf_sign(w_big), w_e_big, w_sum9[6:0]};
      end
    end else if (w_dif8 == 8'd0) begin
      sum = BF16_ZERO;
    end else if (w_e_big <= {5'd0, w_lz}) begin
      sum = BF16_ZERO;
    end else begin
      w_man = 7'(w_dif8 << w_lz);
      sum   = {bf_sign(w_big), w_e_big - {5'd0, w_lz}, w_man};
    end
  end

endmodule

// File: rtl/bfloat_accum.sv
// rtl/bfloat_accum.sv - streaming bfloat16 packet accumulator with result handshake
// Purpose: sums a packet of bfloat16 elements and presents sum and element count.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_data/in_last valid
//   in_ready   out  element accepted this cycle when in_valid
//   in_data    in   bfloat16 element
//   in_last    in   element is last of packet
//   out_valid  out  out_data/out_count valid
//   out_ready  in   consumer accepts result
//   out_data   out  bfloat16 packet sum
//   out_count  out  elements in packet, saturating
module bfloat_accum
  import bfloat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [15:0]      w_sum;
  logic             w_xfer;

  // Operands are captured every edge; only the transfer-edge capture is
  // consumed, because S_WAIT always follows a transfer directly.
  bfloat_add_reg u_add (
    .clk (clk),
    .rst (rst),
    .a   (in_data),
    .b   (r_acc),
    .sum (w_sum)
  );

  assign w_xfer    = in_valid && in_ready;
  assign out_data  = r_acc;
  assign out_count = r_cnt;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_next = r_last ? S_OUT : S_RUN;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_acc   <= BF16_ZERO;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_RUN: begin
          if (w_xfer) begin
            r_last <= in_last;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: r_acc <= w_sum;
        S_OUT: begin
          if (out_ready) begin
            r_acc <= BF16_ZERO;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfloat_accum.sv
// tb/tb_bfloat_accum.sv - self-checking bench for bfloat_accum
module tb_bfloat_accum;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;

  bfloat_accum #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = (-1)^s * m * 2^e with m = 1.man scaled to 128..255.
  // The smaller operand loses its shifted-out bits, the result is renormalised
  // by halving (dropping bits) or doubling.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e_big, m_big, m_small, d, mag;
    logic s_big, s_small;
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = 128 + int'(a[6:0]); mb = 128 + int'(b[6:0]);
    if (ea == 255 || eb == 255) return 16'hFFFF;
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (ea > eb || (ea == eb && ma >= mb)) begin
      e_big = ea; m_big = ma; s_big = a[15]; d = ea - eb; m_small = mb; s_small = b[15];
    end else begin
      e_big = eb; m_big = mb; s_big = b[15]; d = eb - ea; m_small = ma; s_small = a[15];
    end
    m_small = (d > 7) ? 0 : m_small / (1 << d);
    mag = (s_big == s_small) ? m_big + m_small : m_big - m_small;
    if (mag == 0) return 16'h0000;
    while (mag >= 256) begin mag = mag / 2; e_big++; end
    while (mag < 128) begin mag = mag * 2; e_big--; end
    if (e_big >= 255) return 16'hFFFF;
    if (e_big <= 0) return 16'h0000;
    return {s_big, e_big[7:0], mag[6:0]};
  endfunction

  task automatic send(input logic [15:0] d, input logic l);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp_d, input int exp_c, input int hold);
    int k;
    k = 0;
    while (!out_valid && k < 10) begin @(negedge clk); k++; end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_d});
    chk({tag, "_count"}, {24'd0, out_count}, exp_c);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, {16'd0, out_data}, {16'd0, exp_d});
      chk({tag, "_hold_count"}, {24'd0, out_count}, exp_c);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_count"}, {24'd0, out_count}, 32'd0);
  endtask

  initial begin
    logic [15:0] pkt[$];
    logic [15:0] acc, x;
    int len, sat;

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    // 1.0 + 2.0 with latency check
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    chk("lat_wait", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_out", {31'd0, out_valid}, 32'd1);
    get_result("p_1p2", 16'h4040, 2, 0);

    send(16'hBF80, 1'b1);
    get_result("p_single", 16'hBF80, 1, 0);

    send(16'h3FC0, 1'b0);
    send(16'hBFC0, 1'b1);
    get_result("p_cancel", 16'h0000, 2, 0);

    send(16'hBF80, 1'b1);
    get_result("p_bp", 16'hBF80, 1, 5);
    send(16'h3F00, 1'b0);
    send(16'h3F00, 1'b1);
    get_result("p_after_bp", 16'h3F80, 2, 0);

    send(16'h3F80, 1'b0);
    send(16'h7F80, 1'b0);
    send(16'h3F80, 1'b1);
    get_result("p_inf", 16'hFFFF, 3, 0);

    // reset while the second element of a three-element packet is in S_WAIT
    send(16'h4000, 1'b0);
    send(16'h3F80, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid_rel");
    send(16'h4000, 1'b1);
    get_result("p_post_rst", 16'h4000, 1, 0);

    sat = (1 << CNT_W) + 3;
    for (int i = 0; i < sat; i++) send(16'h0000, i == sat - 1);
    get_result("p_sat", 16'h0000, (1 << CNT_W) - 1, 0);

    for (int p = 0; p < 25; p++) begin
      len = int'($urandom_range(1, 6));
      acc = 16'h0000;
      pkt.delete();
      for (int i = 0; i < len; i++) begin
        if (acc[14:7] != 8'd0 && acc != 16'hFFFF && $urandom_range(0, 3) == 0)
          x = acc ^ 16'h8000;
        else if ($urandom_range(0, 9) == 0)
          x = 16'h0000;
        else
          x = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 14)), 7'($urandom_range(0, 127))};
        pkt.push_back(x);
        acc = ref_add(x, acc);
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) @(negedge clk);
        send(pkt[i], i == len - 1);
      end
      get_result("p_rand", acc, len, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
